// File: rtl/id_ex_stage_reg_if.sv
// ID->EX boundary bundle: decode/hazard side drives the master modport, the stage register is the slave.
interface id_ex_stage_reg_if #(
   parameter int unsigned CTRL_W   = 7,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 3,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_REGS = 3,
   parameter int unsigned CNT_W    = 16
);
   logic                         in_valid;
   logic [CTRL_W-1:0]            ctrl_in;
   logic [NUM_DATA*DATA_W-1:0]   data_in;
   logic [NUM_REGS*REG_AW-1:0]   regs_in;
   logic                         stall;
   logic                         flush_lwstall;
   logic                         flush_branch;
   logic                         cnt_clr;

   logic                         out_valid;
   logic [CTRL_W-1:0]            ctrl_out;
   logic [NUM_DATA*DATA_W-1:0]   data_out;
   logic [NUM_REGS*REG_AW-1:0]   regs_out;
   logic [CNT_W-1:0]             stall_cnt;
   logic [CNT_W-1:0]             bubble_cnt;

   modport master (
      output in_valid, ctrl_in, data_in, regs_in,
      output stall, flush_lwstall, flush_branch, cnt_clr,
      input  out_valid, ctrl_out, data_out, regs_out, stall_cnt, bubble_cnt
   );

   modport slave (
      input  in_valid, ctrl_in, data_in, regs_in,
      input  stall, flush_lwstall, flush_branch, cnt_clr,
      output out_valid, ctrl_out, data_out, regs_out, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid tracking, stall hold, dual-source flush
// and saturating stall/bubble counters.
module id_ex_stage_reg #(
   parameter int unsigned       CTRL_W         = 7,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL    = '0,
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       NUM_DATA       = 3,
   parameter int unsigned       REG_AW         = 5,
   parameter int unsigned       NUM_REGS       = 3,
   parameter bit                CLEAR_ON_FLUSH = 1'b0,
   parameter int unsigned       CNT_W          = 16
) (
   input logic              clk,
   input logic              reset,
   id_ex_stage_reg_if.slave bus
);

   localparam int unsigned DATA_LEN = NUM_DATA * DATA_W;
   localparam int unsigned REGS_LEN = NUM_REGS * REG_AW;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                flush_c;
   logic                hold_c;

   logic                valid_q,      valid_d;
   logic [CTRL_W-1:0]   ctrl_q,       ctrl_d;
   logic [DATA_LEN-1:0] data_q,       data_d;
   logic [REGS_LEN-1:0] regs_q,       regs_d;
   logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

   // Flush outranks stall, so a stall only counts when no flush is present.
   assign flush_c = bus.flush_lwstall | bus.flush_branch;
   assign hold_c  = bus.stall & ~flush_c;

   // Pipeline payload next state; ctrl_in is only looked at on a true load.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      regs_d  = regs_q;
      if (flush_c) begin
         valid_d = 1'b0;
         ctrl_d  = BUBBLE_CTRL;
         if (CLEAR_ON_FLUSH) begin
            data_d = '0;
            regs_d = '0;
         end
      end else if (!bus.stall) begin
         valid_d = bus.in_valid;
         ctrl_d  = bus.in_valid ? bus.ctrl_in : BUBBLE_CTRL;
         data_d  = bus.data_in;
         regs_d  = bus.regs_in;
      end
   end

   // Saturating counters; a clear wins over any increment in the same cycle.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (bus.cnt_clr) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else begin
         if (hold_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (flush_c && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         ctrl_q       <= BUBBLE_CTRL;
         data_q       <= '0;
         regs_q       <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         ctrl_q       <= ctrl_d;
         data_q       <= data_d;
         regs_q       <= regs_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.ctrl_out   = ctrl_q;
   assign bus.data_out   = data_q;
   assign bus.regs_out   = regs_q;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a default instance and a clear-on-flush, 3-bit-counter
// instance share one random stimulus stream and are checked against a reference model.
module tb_id_ex_stage_reg;

   localparam int unsigned CTRL_W = 7;
   localparam int unsigned DLEN   = 96;
   localparam int unsigned RLEN   = 15;
   localparam logic [CTRL_W-1:0] BUB = 7'h00;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg_if                if0 ();
   id_ex_stage_reg_if #(.CNT_W(3))   if1 ();

   id_ex_stage_reg dut0 (.clk(clk), .reset(reset), .bus(if0));
   id_ex_stage_reg #(.CLEAR_ON_FLUSH(1'b1), .CNT_W(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));

   assign if1.in_valid      = if0.in_valid;
   assign if1.ctrl_in       = if0.ctrl_in;
   assign if1.data_in       = if0.data_in;
   assign if1.regs_in       = if0.regs_in;
   assign if1.stall         = if0.stall;
   assign if1.flush_lwstall = if0.flush_lwstall;
   assign if1.flush_branch  = if0.flush_branch;
   assign if1.cnt_clr       = if0.cnt_clr;

   // Reference state, index 0 = default instance, 1 = clear-on-flush / 3-bit counters.
   logic              m_valid [2];
   logic [CTRL_W-1:0] m_ctrl  [2];
   logic [DLEN-1:0]   m_data  [2];
   logic [RLEN-1:0]   m_regs  [2];
   int                m_stall [2];
   int                m_bub   [2];
   bit                clr_on_flush [2] = '{1'b0, 1'b1};
   int                cnt_max [2] = '{65535, 7};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0; m_ctrl[k] = BUB; m_data[k] = '0; m_regs[k] = '0;
         m_stall[k] = 0;    m_bub[k]  = 0;
      end
   endtask

   // One clock edge worth of behaviour, evaluated from the inputs about to be sampled.
   task automatic model_step();
      bit fl;
      fl = if0.flush_lwstall || if0.flush_branch;
      for (int k = 0; k < 2; k++) begin
         if (fl) begin
            m_valid[k] = 1'b0;
            m_ctrl[k]  = BUB;
            if (clr_on_flush[k]) begin m_data[k] = '0; m_regs[k] = '0; end
            m_bub[k] = sat_inc(m_bub[k], cnt_max[k]);
         end else if (if0.stall) begin
            m_stall[k] = sat_inc(m_stall[k], cnt_max[k]);
         end else begin
            m_valid[k] = if0.in_valid;
            m_ctrl[k]  = if0.in_valid ? if0.ctrl_in : BUB;
            m_data[k]  = if0.data_in;
            m_regs[k]  = if0.regs_in;
         end
         if (if0.cnt_clr) begin m_stall[k] = 0; m_bub[k] = 0; end
      end
   endtask

   task automatic compare_all(input string ph);
      chk({ph, ".d0.valid"}, 128'(if0.out_valid),  128'(m_valid[0]));
      chk({ph, ".d0.ctrl"},  128'(if0.ctrl_out),   128'(m_ctrl[0]));
      chk({ph, ".d0.data"},  128'(if0.data_out),   128'(m_data[0]));
      chk({ph, ".d0.regs"},  128'(if0.regs_out),   128'(m_regs[0]));
      chk({ph, ".d0.scnt"},  128'(if0.stall_cnt),  128'(m_stall[0]));
      chk({ph, ".d0.bcnt"},  128'(if0.bubble_cnt), 128'(m_bub[0]));
      chk({ph, ".d1.valid"}, 128'(if1.out_valid),  128'(m_valid[1]));
      chk({ph, ".d1.ctrl"},  128'(if1.ctrl_out),   128'(m_ctrl[1]));
      chk({ph, ".d1.data"},  128'(if1.data_out),   128'(m_data[1]));
      chk({ph, ".d1.regs"},  128'(if1.regs_out),   128'(m_regs[1]));
      chk({ph, ".d1.scnt"},  128'(if1.stall_cnt),  128'(m_stall[1]));
      chk({ph, ".d1.bcnt"},  128'(if1.bubble_cnt), 128'(m_bub[1]));
   endtask

   task automatic tick(input string ph);
      model_step();
      @(posedge clk);
      #1;
      compare_all(ph);
   endtask

   task automatic rand_payload();
      if0.in_valid = ($urandom_range(0, 99) < 70);
      if0.ctrl_in  = CTRL_W'($urandom);
      if0.data_in  = {$urandom, $urandom, $urandom};
      if0.regs_in  = RLEN'($urandom);
   endtask

   task automatic ctl(input bit st, input bit fl, input bit fb, input bit cc);
      if0.stall = st; if0.flush_lwstall = fl; if0.flush_branch = fb; if0.cnt_clr = cc;
   endtask

   initial begin
      reset = 1'b1;
      ctl(0, 0, 0, 0);
      if0.in_valid = 1'b0; if0.ctrl_in = '0; if0.data_in = '0; if0.regs_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;

      // Directed first load.
      if0.in_valid = 1'b1;
      if0.ctrl_in  = 7'h5A;
      if0.data_in  = {32'h33, 32'h22, 32'h11};
      if0.regs_in  = {5'd3, 5'd2, 5'd1};
      tick("load");
      chk("tp.ctrl", 128'(if0.ctrl_out), 128'(7'h5A));
      chk("tp.data", 128'(if0.data_out), 128'({32'h33, 32'h22, 32'h11}));

      // Four-cycle stall with changing inputs.
      ctl(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin rand_payload(); tick("stall"); end
      chk("tp.stall4", 128'(if0.stall_cnt), 128'(4));
      chk("tp.bub0",   128'(if0.bubble_cnt), 128'(0));

      // Flush together with stall.
      ctl(1, 1, 0, 0); rand_payload(); tick("flush_stall");
      chk("tp.bub1",  128'(if0.bubble_cnt), 128'(1));
      chk("tp.clr1",  128'(if1.data_out), 128'(0));

      // Reload, then both flush sources at once.
      ctl(0, 0, 0, 0); rand_payload(); if0.in_valid = 1'b1; tick("reload");
      ctl(0, 1, 1, 0); rand_payload(); tick("dual_flush");
      chk("tp.bub2", 128'(if0.bubble_cnt), 128'(2));

      // Ten stalls saturate the 3-bit counter, then clear together with stall.
      ctl(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin rand_payload(); tick("sat"); end
      chk("tp.sat7", 128'(if1.stall_cnt), 128'(7));
      ctl(1, 0, 0, 1); tick("clr_stall");
      chk("tp.clr0", 128'(if1.stall_cnt), 128'(0));

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rand_payload();
         ctl($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
         tick("rand");
      end

      // Asynchronous reset between edges during a stall.
      ctl(0, 0, 0, 0); rand_payload(); if0.in_valid = 1'b1; tick("pre_rst");
      ctl(1, 0, 0, 0); tick("pre_rst_stall");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      #1;
      reset = 1'b0;
      ctl(0, 0, 0, 0); rand_payload(); if0.in_valid = 1'b1;
      tick("post_rst");
      chk("tp.post_valid", 128'(if0.out_valid), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID→EX pipeline boundary register for the RISC-V core.
- Carries a generic WB/MEM/EX control bundle, N data lanes (rs1/rs2 data, immediate, PC, ...) and register-index fields.
- Adds stage valid tracking, a hold (stall) mode, two independent flush sources with defined priority, and saturating stall/bubble performance counters.
- Sits between the decode/hazard unit and the EX stage.

Parameters:
- CTRL_W, 7: width of the packed control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]).
- BUBBLE_CTRL, 0: control value loaded on a flush; must be a no-op encoding.
- DATA_W, 32: width of each data lane.
- NUM_DATA, 3: number of data lanes (≥1).
- REG_AW, 5: width of each register-index field.
- NUM_REGS, 3: number of register-index fields (rs1, rs2, rd).
- CLEAR_ON_FLUSH, 0: 1 = a flush also zeroes data and register fields; 0 = a flush leaves them unchanged.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID stage holds a real instruction.
- ctrl_in  in  CTRL_W  control bundle from decode.
- data_in  in  NUM_DATA*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- regs_in  in  NUM_REGS*REG_AW  field k occupies bits [k*REG_AW +: REG_AW].
- stall  in  1  hold the current contents.
- flush_lwstall  in  1  insert a bubble (load-use hazard).
- flush_branch  in  1  insert a bubble (taken branch/jump).
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  EX stage holds a real instruction.
- ctrl_out  out  CTRL_W  registered control bundle.
- data_out  out  NUM_DATA*DATA_W  registered data lanes.
- regs_out  out  NUM_REGS*REG_AW  registered register-index fields.
- stall_cnt  out  CNT_W  number of cycles spent in hold.
- bubble_cnt  out  CNT_W  number of bubbles inserted.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-stall or mid-flush):
  - out_valid=0, ctrl_out=BUBBLE_CTRL.
  - data_out, regs_out, stall_cnt, bubble_cnt all 0.
- Per-rising-edge priority, highest first:
  - Flush: flush_lwstall or flush_branch → ctrl_out←BUBBLE_CTRL, out_valid←0. data_out/regs_out ← 0 if CLEAR_ON_FLUSH=1, otherwise held.
  - Stall: stall=1 with no flush → every output register holds.
  - Load: otherwise ctrl_out←ctrl_in, data_out←data_in, regs_out←regs_in, out_valid←in_valid.
- A flush beats a stall. If both are asserted, the result is a bubble and the cycle counts as a bubble, not a stall.
- If both flush sources are asserted in the same cycle, one bubble is inserted and bubble_cnt increments by 1.
- Load with in_valid=0: the fields are still captured, but ctrl_out←BUBBLE_CTRL so a non-valid slot can never write state.
- Latency: exactly 1 cycle from input to output. No combinational path from any input to any output.
- Counters:
  - stall_cnt increments on each edge where the stall branch is taken.
  - bubble_cnt increments on each edge where the flush branch is taken.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - cnt_clr=1 forces both to 0 on the edge and overrides any increment in that cycle. The pipeline registers are unaffected by cnt_clr.
- X-safety: with flush or stall active, the values on ctrl_in, data_in and regs_in must not affect ctrl_out.

Test Plan:
- Reset release, then in_valid=1, ctrl_in=7'h5A, data lanes 32'h11/22/33, regs 1/2/3 → next edge: out_valid=1, ctrl_out=5A, data_out=33_22_11, regs_out=3_2_1.
- stall held high for 4 cycles while the inputs change every cycle → outputs frozen at their pre-stall values; stall_cnt=4, bubble_cnt=0.
- flush_lwstall and stall both high for 1 cycle, CLEAR_ON_FLUSH=0 → ctrl_out=BUBBLE_CTRL, out_valid=0, data/regs unchanged; bubble_cnt=1, stall_cnt unchanged. Repeat with CLEAR_ON_FLUSH=1 → data/regs=0.
- flush_lwstall and flush_branch high in the same cycle → a single bubble; bubble_cnt increments by exactly 1.
- CNT_W=3, stall held for 10 cycles → stall_cnt sticks at 7. Then cnt_clr together with stall → stall_cnt=0 on that edge.
- Assert reset asynchronously between edges during a stall → all outputs go to reset values immediately, without waiting for an edge. On deassert, the first edge performs a normal load.
